// File: rtl/amm_cmd_splitter.sv
// Splits one byte-granular test command into single-word Avalon-MM accesses
// with per-word byteenables and a per-word incrementing write-data pattern.
module amm_cmd_splitter #(
    parameter int DATA_W     = 128,
    parameter int BE_W       = DATA_W / 8,
    parameter int ADDR_W     = 32,
    parameter int AMM_ADDR_W = ADDR_W - $clog2(DATA_W / 8),
    parameter int LEN_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_op_i,
    input  logic [ADDR_W-1:0]     cmd_addr_i,
    input  logic [LEN_W-1:0]      cmd_len_i,
    input  logic [7:0]            cmd_pattern_i,
    output logic [AMM_ADDR_W-1:0] amm_address_o,
    output logic                  amm_read_o,
    output logic                  amm_write_o,
    output logic [DATA_W-1:0]     amm_writedata_o,
    output logic [BE_W-1:0]       amm_byteenable_o,
    input  logic                  amm_waitrequest_i,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int OFF_W = $clog2(BE_W);
    localparam int CNT_W = LEN_W - OFF_W + 1;
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [AMM_ADDR_W-1:0] ADDR_ONE = AMM_ADDR_W'(1);
    localparam logic [LEN_W:0]        END_ONE  = (LEN_W + 1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        FIN
    } state_e;

    state_e                  state_q, state_d;
    logic                    op_q, op_d;
    logic [7:0]              pat_q, pat_d;
    logic [OFF_W-1:0]        off_q, off_d;
    logic [OFF_W-1:0]        endlo_q, endlo_d;
    logic [CNT_W-1:0]        nwords_q, nwords_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [AMM_ADDR_W-1:0]   addr_q, addr_d;
    logic                    read_q, read_d;
    logic                    write_q, write_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [BE_W-1:0]         be_q, be_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [OFF_W-1:0]        acc_off;
    logic [LEN_W:0]          acc_end;
    logic [CNT_W-1:0]        acc_nwords;
    logic [CNT_W-1:0]        cnt_nxt;
    logic                    last_word;

    // BE_W-1-hi equals ~hi in OFF_W bits, so the upper bound is a right shift by ~hi.
    function automatic logic [BE_W-1:0] word_be(input logic [CNT_W-1:0] n,
                                               input logic [CNT_W-1:0] nw,
                                               input logic [OFF_W-1:0] off,
                                               input logic [OFF_W-1:0] endlo);
        logic [BE_W-1:0]  ones;
        logic [OFF_W-1:0] lo;
        logic [OFF_W-1:0] hi;
        ones = '1;
        lo   = (n == '0) ? off : '0;
        hi   = (n == nw - CNT_ONE) ? endlo : '1;
        return (ones << lo) & (ones >> (~hi));
    endfunction

    function automatic logic [DATA_W-1:0] fill(input logic [7:0] b);
        return {BE_W{b}};
    endfunction

    always_comb begin
        acc_off    = cmd_addr_i[OFF_W-1:0];
        acc_end    = (LEN_W + 1)'(acc_off) + {1'b0, cmd_len_i} - END_ONE;
        acc_nwords = acc_end[LEN_W:OFF_W] + CNT_ONE;
        cnt_nxt    = cnt_q + CNT_ONE;
        last_word  = (cnt_q == nwords_q - CNT_ONE);
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        pat_d    = pat_q;
        off_d    = off_q;
        endlo_d  = endlo_q;
        nwords_d = nwords_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        read_d   = read_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i && ready_q) begin
                    op_d     = cmd_op_i;
                    pat_d    = cmd_pattern_i;
                    off_d    = acc_off;
                    endlo_d  = acc_end[OFF_W-1:0];
                    nwords_d = acc_nwords;
                    cnt_d    = '0;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                    if (cmd_len_i == '0) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        addr_d  = AMM_ADDR_W'(cmd_addr_i >> OFF_W);
                        read_d  = ~cmd_op_i;
                        write_d = cmd_op_i;
                        be_d    = word_be('0, acc_nwords, acc_off, acc_end[OFF_W-1:0]);
                        wdata_d = cmd_op_i ? fill(cmd_pattern_i) : '0;
                    end
                end
            end
            ISSUE: begin
                if (!amm_waitrequest_i) begin
                    if (last_word) begin
                        state_d = IDLE;
                        addr_d  = '0;
                        read_d  = 1'b0;
                        write_d = 1'b0;
                        be_d    = '0;
                        wdata_d = '0;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d   = cnt_nxt;
                        addr_d  = addr_q + ADDR_ONE;
                        be_d    = word_be(cnt_nxt, nwords_q, off_q, endlo_q);
                        wdata_d = op_q ? fill(pat_q + 8'(cnt_nxt)) : '0;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            op_q     <= 1'b0;
            pat_q    <= '0;
            off_q    <= '0;
            endlo_q  <= '0;
            nwords_q <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            be_q     <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            pat_q    <= pat_d;
            off_q    <= off_d;
            endlo_q  <= endlo_d;
            nwords_q <= nwords_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            read_q   <= read_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign cmd_ready_o      = ready_q;
    assign amm_address_o    = addr_q;
    assign amm_read_o       = read_q;
    assign amm_write_o      = write_q;
    assign amm_writedata_o  = wdata_q;
    assign amm_byteenable_o = be_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;

endmodule

// File: tb/tb_amm_cmd_splitter.sv
// Directed bench for amm_cmd_splitter (DATA_W=128, ADDR_W=32, LEN_W=16).
module tb_amm_cmd_splitter;

    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic         cmd_valid_i;
    logic         cmd_ready_o;
    logic         cmd_op_i;
    logic [31:0]  cmd_addr_i;
    logic [15:0]  cmd_len_i;
    logic [7:0]   cmd_pattern_i;
    logic [27:0]  amm_address_o;
    logic         amm_read_o;
    logic         amm_write_o;
    logic [127:0] amm_writedata_o;
    logic [15:0]  amm_byteenable_o;
    logic         amm_waitrequest_i;
    logic         busy_o;
    logic         done_o;

    int n_chk  = 0;
    int n_pass = 0;

    amm_cmd_splitter #(
        .DATA_W (128),
        .ADDR_W (32),
        .LEN_W  (16)
    ) dut (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .cmd_valid_i       (cmd_valid_i),
        .cmd_ready_o       (cmd_ready_o),
        .cmd_op_i          (cmd_op_i),
        .cmd_addr_i        (cmd_addr_i),
        .cmd_len_i         (cmd_len_i),
        .cmd_pattern_i     (cmd_pattern_i),
        .amm_address_o     (amm_address_o),
        .amm_read_o        (amm_read_o),
        .amm_write_o       (amm_write_o),
        .amm_writedata_o   (amm_writedata_o),
        .amm_byteenable_o  (amm_byteenable_o),
        .amm_waitrequest_i (amm_waitrequest_i),
        .busy_o            (busy_o),
        .done_o            (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [127:0] fill(input logic [7:0] b);
        return {16{b}};
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic op, input logic [31:0] addr, input logic [15:0] len,
                        input logic [7:0] pat);
        chk("accept_ready", cmd_ready_o, 1'b1);
        cmd_op_i      = op;
        cmd_addr_i    = addr;
        cmd_len_i     = len;
        cmd_pattern_i = pat;
        cmd_valid_i   = 1'b1;
        step();
        cmd_valid_i   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_i = 1'b0; cmd_valid_i = 1'b0; cmd_op_i = 1'b0; cmd_addr_i = '0;
        cmd_len_i = '0; cmd_pattern_i = '0; amm_waitrequest_i = 1'b0;
        #12;
        chk("rst_ready", cmd_ready_o, 1'b1);
        chk("rst_read",  amm_read_o, 1'b0);
        chk("rst_write", amm_write_o, 1'b0);
        chk("rst_addr",  amm_address_o, 28'h0);
        chk("rst_be",    amm_byteenable_o, 16'h0);
        chk("rst_wdata", amm_writedata_o, 128'h0);
        chk("rst_busy",  busy_o, 1'b0);
        chk("rst_done",  done_o, 1'b0);
        rst_n_i = 1'b1;
        step();

        // single-word write: off 3, end 7
        send(1'b1, 32'h13, 16'd5, 8'hA5);
        chk("t1_write", amm_write_o, 1'b1);
        chk("t1_read",  amm_read_o, 1'b0);
        chk("t1_addr",  amm_address_o, 28'h1);
        chk("t1_be",    amm_byteenable_o, 16'h00F8);
        chk("t1_wdata", amm_writedata_o, fill(8'hA5));
        chk("t1_busy",  busy_o, 1'b1);
        chk("t1_ready", cmd_ready_o, 1'b0);
        chk("t1_done0", done_o, 1'b0);
        step();
        chk("t1_done",  done_o, 1'b1);
        chk("t1_wr_off", amm_write_o, 1'b0);
        chk("t1_be_off", amm_byteenable_o, 16'h0);
        chk("t1_idle_busy", busy_o, 1'b0);

        // multi-word read accepted in the done cycle: off 14, end 33, 3 words
        send(1'b0, 32'h0E, 16'd20, 8'h00);
        chk("t2_w0_addr", amm_address_o, 28'h0);
        chk("t2_w0_be",   amm_byteenable_o, 16'hC000);
        chk("t2_w0_rd",   amm_read_o, 1'b1);
        chk("t2_w0_wd",   amm_writedata_o, 128'h0);
        chk("t2_w0_done", done_o, 1'b0);
        step();
        chk("t2_w1_addr", amm_address_o, 28'h1);
        chk("t2_w1_be",   amm_byteenable_o, 16'hFFFF);
        chk("t2_w1_rd",   amm_read_o, 1'b1);
        step();
        chk("t2_w2_addr", amm_address_o, 28'h2);
        chk("t2_w2_be",   amm_byteenable_o, 16'h0003);
        chk("t2_w2_rd",   amm_read_o, 1'b1);
        step();
        chk("t2_done",    done_o, 1'b1);
        chk("t2_rd_off",  amm_read_o, 1'b0);
        step();
        chk("t2_done_pulse", done_o, 1'b0);

        // same read, word 1 stalled for three cycles
        send(1'b0, 32'h0E, 16'd20, 8'h00);
        chk("t3_w0_be", amm_byteenable_o, 16'hC000);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("t3_hold_addr", amm_address_o, 28'h1);
            chk("t3_hold_be",   amm_byteenable_o, 16'hFFFF);
            chk("t3_hold_rd",   amm_read_o, 1'b1);
            chk("t3_hold_done", done_o, 1'b0);
            amm_waitrequest_i = (i < 3);
            step();
        end
        chk("t3_w2_addr", amm_address_o, 28'h2);
        chk("t3_w2_be",   amm_byteenable_o, 16'h0003);
        step();
        chk("t3_done", done_o, 1'b1);
        step();

        // zero-length write
        send(1'b1, 32'h40, 16'd0, 8'h55);
        chk("t4_done",  done_o, 1'b1);
        chk("t4_ready", cmd_ready_o, 1'b0);
        chk("t4_write", amm_write_o, 1'b0);
        chk("t4_read",  amm_read_o, 1'b0);
        chk("t4_busy",  busy_o, 1'b1);
        step();
        chk("t4_done_off", done_o, 1'b0);
        chk("t4_ready_on", cmd_ready_o, 1'b1);
        chk("t4_write2",   amm_write_o, 1'b0);

        // word address wrap: off 8, end 23
        send(1'b1, 32'hFFFF_FFF8, 16'd16, 8'h3C);
        chk("t5_w0_addr",  amm_address_o, 28'hFFFFFFF);
        chk("t5_w0_be",    amm_byteenable_o, 16'hFF00);
        chk("t5_w0_wdata", amm_writedata_o, fill(8'h3C));
        step();
        chk("t5_w1_addr",  amm_address_o, 28'h0);
        chk("t5_w1_be",    amm_byteenable_o, 16'h00FF);
        chk("t5_w1_wdata", amm_writedata_o, fill(8'h3D));
        step();
        chk("t5_done", done_o, 1'b1);
        step();

        // reset during word 2 of a 3-word write; a stray command is offered while busy
        send(1'b1, 32'h100, 16'd48, 8'h10);
        chk("t6_w0_addr",  amm_address_o, 28'h10);
        chk("t6_w0_wdata", amm_writedata_o, fill(8'h10));
        cmd_op_i = 1'b0; cmd_addr_i = 32'h200; cmd_len_i = 16'd0; cmd_valid_i = 1'b1;
        step();
        chk("t6_w1_addr",  amm_address_o, 28'h11);
        chk("t6_w1_write", amm_write_o, 1'b1);
        chk("t6_w1_read",  amm_read_o, 1'b0);
        chk("t6_w1_wdata", amm_writedata_o, fill(8'h11));
        chk("t6_w1_done",  done_o, 1'b0);
        step();
        chk("t6_w2_addr",  amm_address_o, 28'h12);
        chk("t6_w2_wdata", amm_writedata_o, fill(8'h12));
        cmd_valid_i = 1'b0;
        rst_n_i = 1'b0;
        #1;
        chk("t6_rst_write", amm_write_o, 1'b0);
        chk("t6_rst_be",    amm_byteenable_o, 16'h0);
        chk("t6_rst_addr",  amm_address_o, 28'h0);
        chk("t6_rst_wdata", amm_writedata_o, 128'h0);
        chk("t6_rst_busy",  busy_o, 1'b0);
        chk("t6_rst_ready", cmd_ready_o, 1'b1);
        #10;
        rst_n_i = 1'b1;
        step();
        chk("t6_rel_ready", cmd_ready_o, 1'b1);
        chk("t6_rel_done",  done_o, 1'b0);
        chk("t6_rel_write", amm_write_o, 1'b0);
        step();
        chk("t6_rel_done2", done_o, 1'b0);
        chk("t6_rel_busy",  busy_o, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
